// File: rtl/benes_ctrl_loader_pkg.sv
// benes_ctrl_loader_pkg: shared sizing helpers and loader state encoding
package benes_ctrl_loader_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, FULL, ARMED} benes_ld_state_t;
  function automatic int benes_ctrl_bits(int n);
    return (2 * $clog2(n) - 1) * (n / 2);
  endfunction
  function automatic int benes_beats(int n, int w);
    return (benes_ctrl_bits(n) + w - 1) / w;
  endfunction
endpackage

// File: rtl/benes_ctrl_loader.sv
// benes_ctrl_loader: assembles Benes switch settings in a shadow and swaps them in at a frame boundary
module benes_ctrl_loader
  import benes_ctrl_loader_pkg::*;
#(
  parameter int N_PORTS = 8,
  parameter int CFG_W = 8,
  localparam int CTRL_BITS = benes_ctrl_bits(N_PORTS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [CFG_W-1:0]     cfg_data,
  input  logic                 cfg_last,
  input  logic                 commit_req,
  input  logic                 frame_start,
  output logic [CTRL_BITS-1:0] switch_set,
  output logic                 swap_done,
  output logic                 cfg_err,
  output logic                 armed
);
  localparam int BEATS = benes_beats(N_PORTS, CFG_W);
  localparam int CNT_W = $clog2(BEATS + 1);
  benes_ld_state_t state;
  logic [CNT_W-1:0] beat_cnt;
  logic [CTRL_BITS-1:0] shadow;
  logic beat_ok, last_beat;
  // handshake and framing decode from the current state
  always_comb begin
    cfg_ready = (state == IDLE) || (state == LOAD);
    armed = state == ARMED;
    beat_ok = cfg_valid && cfg_ready;
    last_beat = beat_cnt == CNT_W'(BEATS - 1);
  end
  // loader FSM, beat counter, shadow assembly and active-register swap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      beat_cnt <= '0;
      shadow <= '0;
      switch_set <= '0;
      swap_done <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      swap_done <= 1'b0;
      cfg_err <= 1'b0;
      if (beat_ok) begin
        for (int i = 0; i < CTRL_BITS; i++)
          if (beat_cnt == CNT_W'(i / CFG_W)) shadow[i] <= cfg_data[i % CFG_W];
        if (cfg_last != last_beat) begin
          cfg_err <= 1'b1;
          beat_cnt <= '0;
          state <= IDLE;
        end else if (last_beat) begin
          beat_cnt <= '0;
          state <= FULL;
        end else begin
          beat_cnt <= beat_cnt + CNT_W'(1);
          state <= LOAD;
        end
      end
      if (state == FULL && commit_req) state <= ARMED;
      if (state == ARMED && frame_start) begin
        switch_set <= shadow;
        swap_done <= 1'b1;
        beat_cnt <= '0;
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_benes_ctrl_loader.sv
// tb_benes_ctrl_loader: scoreboard bench for the Benes control loader
module tb_benes_ctrl_loader;
  logic clk = 0, rst = 1;
  logic cfg_valid = 0, cfg_last = 0, commit_req = 0, frame_start = 0;
  logic [7:0] cfg_data = 0;
  logic cfg_ready, swap_done, cfg_err, armed;
  logic [19:0] switch_set;
  logic [19:0] sb[$];
  int checks = 0, errors = 0, swaps = 0;
  benes_ctrl_loader #(.N_PORTS(8), .CFG_W(8)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_data(cfg_data), .cfg_last(cfg_last), .commit_req(commit_req),
    .frame_start(frame_start), .switch_set(switch_set), .swap_done(swap_done),
    .cfg_err(cfg_err), .armed(armed)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [19:0] model(input logic [7:0] b0, b1, b2);
    logic [23:0] t;
    t = {b2, b1, b0};
    return t[19:0];
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] d, input logic l);
    chk("ready_on_send", 32'(cfg_ready), 32'd1);
    cfg_valid = 1; cfg_data = d; cfg_last = l;
    tick();
    cfg_valid = 0; cfg_last = 0;
  endtask
  task automatic load(input logic [7:0] b0, b1, b2);
    send(b0, 0); send(b1, 0); send(b2, 1);
  endtask
  task automatic commit();
    commit_req = 1; tick(); commit_req = 0;
  endtask
  task automatic frame();
    frame_start = 1; tick(); frame_start = 0;
  endtask
  always @(negedge clk) if (!rst && swap_done) begin
    swaps++;
    if (sb.size() == 0) chk("sb_unexpected_swap", 32'd1, 32'd0);
    else chk("sb_swap_value", 32'(switch_set), 32'(sb.pop_front()));
  end
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    #2;
    chk("rst_switch_set", 32'(switch_set), 32'h0);
    chk("rst_ready", 32'(cfg_ready), 32'd1);
    chk("rst_armed", 32'(armed), 32'd0);
    tick(); tick();
    rst = 0;
    tick();
    frame();
    chk("idle_frame_noop", 32'(switch_set), 32'h0);
    load(8'hA5, 8'h3C, 8'hFF);
    chk("full_ready", 32'(cfg_ready), 32'd0);
    chk("full_not_armed", 32'(armed), 32'd0);
    commit();
    chk("armed_set", 32'(armed), 32'd1);
    sb.push_back(model(8'hA5, 8'h3C, 8'hFF));
    frame();
    chk("swap_done_pulse", 32'(swap_done), 32'd1);
    chk("swap_value", 32'(switch_set), 32'hF3CA5);
    chk("armed_clear", 32'(armed), 32'd0);
    tick();
    chk("swap_done_one_cycle", 32'(swap_done), 32'd0);
    send(8'h11, 0); send(8'h22, 1);
    chk("err_early_last", 32'(cfg_err), 32'd1);
    chk("err_idle_ready", 32'(cfg_ready), 32'd1);
    chk("err_keep_active", 32'(switch_set), 32'hF3CA5);
    tick();
    chk("err_one_cycle", 32'(cfg_err), 32'd0);
    send(8'h11, 0); send(8'h22, 0); send(8'h33, 0);
    chk("err_missing_last", 32'(cfg_err), 32'd1);
    chk("err2_keep_active", 32'(switch_set), 32'hF3CA5);
    commit();
    chk("err_commit_ignored", 32'(armed), 32'd0);
    load(8'h12, 8'h34, 8'h56);
    cfg_valid = 1; cfg_data = 8'hEE; cfg_last = 1;
    tick();
    chk("full_hold_ready0", 32'(cfg_ready), 32'd0);
    chk("full_hold_no_err", 32'(cfg_err), 32'd0);
    tick();
    cfg_valid = 0; cfg_last = 0;
    commit_req = 1; frame_start = 1;
    tick();
    commit_req = 0; frame_start = 0;
    chk("same_cycle_armed", 32'(armed), 32'd1);
    chk("same_cycle_no_swap", 32'(swap_done), 32'd0);
    chk("same_cycle_hold", 32'(switch_set), 32'hF3CA5);
    sb.push_back(model(8'h12, 8'h34, 8'h56));
    frame();
    chk("late_swap", 32'(switch_set), 32'h63412);
    load(8'h77, 8'h88, 8'h99);
    chk("b2b_hold_first", 32'(switch_set), 32'h63412);
    commit();
    chk("b2b_hold_armed", 32'(switch_set), 32'h63412);
    sb.push_back(model(8'h77, 8'h88, 8'h99));
    frame();
    chk("b2b_second_swap", 32'(switch_set), 32'h98877);
    tick();
    load(8'hAB, 8'hCD, 8'hEF);
    commit();
    chk("pre_rst_armed", 32'(armed), 32'd1);
    #2 rst = 1;
    #1;
    chk("async_rst_switch_set", 32'(switch_set), 32'h0);
    chk("async_rst_armed", 32'(armed), 32'd0);
    chk("async_rst_ready", 32'(cfg_ready), 32'd1);
    tick();
    rst = 0;
    tick(); tick();
    chk("sb_drained", 32'(sb.size()), 32'd0);
    chk("swap_count", 32'(swaps), 32'd3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
